// File: rtl/l2_mem_arbiter.sv
// Round-robin arbiter sharing the L2 line port between the L1 I-cache and D-cache.
// One line transaction in flight; address/write line latched at grant; sticky watchdog.
module l2_mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int LINE_W  = 128,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_address,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        IDLE,
        I_RD,
        D_RD,
        D_WR,
        DONE
    } state_e;

    localparam logic [9:0] TMO = 10'(TIMEOUT);

    state_e            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [9:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              i_req, d_req, pick_i;

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        i_req    = icache_read;
        d_req    = dcache_read | dcache_write;
        // On a tie the side that did not win last time takes the grant
        pick_i   = i_req && (!d_req || last_d_q);
        unique case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    cnt_d = '0;
                    if (pick_i) begin
                        state_d  = I_RD;
                        addr_d   = icache_address;
                        last_d_d = 1'b0;
                    end else begin
                        addr_d   = dcache_address;
                        last_d_d = 1'b1;
                        if (dcache_write) begin
                            state_d = D_WR;
                            wdata_d = dcache_wdata;
                        end else begin
                            state_d = D_RD;
                        end
                    end
                end
            end
            I_RD, D_RD, D_WR: begin
                if (l2_resp) begin
                    state_d = DONE;
                end else if (cnt_q != TMO) begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        err_d = err_q | (cnt_d == TMO);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    assign l2_read      = (state_q == I_RD) || (state_q == D_RD);
    assign l2_write     = (state_q == D_WR);
    assign l2_address   = addr_q;
    assign l2_wdata     = wdata_q;
    assign icache_resp  = (state_q == I_RD) && l2_resp;
    assign dcache_resp  = ((state_q == D_RD) || (state_q == D_WR)) && l2_resp;
    assign icache_rdata = icache_resp ? l2_rdata : '0;
    assign dcache_rdata = dcache_resp ? l2_rdata : '0;
    assign timeout_err  = err_q;

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// Bench for l2_mem_arbiter: directed scenarios plus random traffic checked
// every cycle against a transaction-level reference model.
module tb_l2_mem_arbiter;

    localparam int TMO = 8;

    logic         clk;
    logic         rst_n;
    logic         icache_read;
    logic [15:0]  icache_address;
    logic [127:0] icache_rdata;
    logic         icache_resp;
    logic         dcache_read;
    logic         dcache_write;
    logic [15:0]  dcache_address;
    logic [127:0] dcache_wdata;
    logic [127:0] dcache_rdata;
    logic         dcache_resp;
    logic         l2_read;
    logic         l2_write;
    logic [15:0]  l2_address;
    logic [127:0] l2_wdata;
    logic [127:0] l2_rdata;
    logic         l2_resp;
    logic         timeout_err;

    l2_mem_arbiter #(
        .ADDR_W (16),
        .LINE_W (128),
        .TIMEOUT(TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icache_read   (icache_read),
        .icache_address(icache_address),
        .icache_rdata  (icache_rdata),
        .icache_resp   (icache_resp),
        .dcache_read   (dcache_read),
        .dcache_write  (dcache_write),
        .dcache_address(dcache_address),
        .dcache_wdata  (dcache_wdata),
        .dcache_rdata  (dcache_rdata),
        .dcache_resp   (dcache_resp),
        .l2_read       (l2_read),
        .l2_write      (l2_write),
        .l2_address    (l2_address),
        .l2_wdata      (l2_wdata),
        .l2_rdata      (l2_rdata),
        .l2_resp       (l2_resp),
        .timeout_err   (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: phase 0 = no transaction, 1 = line transfer in flight,
    // 2 = turnaround after completion
    int           m_ph;
    bit           m_own_d;
    bit           m_wr;
    bit           m_last_d;
    logic [15:0]  m_addr;
    logic [127:0] m_wdata;
    int           m_wait;
    bit           m_err;

    logic         cap_ir, cap_dr;
    logic [127:0] cap_irdata, cap_drdata;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_ph     = 0;
        m_own_d  = 1'b0;
        m_wr     = 1'b0;
        m_last_d = 1'b1;
        m_addr   = '0;
        m_wdata  = '0;
        m_wait   = 0;
        m_err    = 1'b0;
    endtask

    task automatic model_update();
        bit ir, dr, take_i;
        if (m_ph == 0) begin
            ir = icache_read;
            dr = dcache_read | dcache_write;
            if (ir || dr) begin
                take_i   = ir && (!dr || m_last_d);
                m_own_d  = !take_i;
                m_last_d = !take_i;
                m_addr   = take_i ? icache_address : dcache_address;
                m_wr     = !take_i && dcache_write;
                if (m_wr) m_wdata = dcache_wdata;
                m_wait   = 0;
                m_ph     = 1;
            end
        end else if (m_ph == 1) begin
            if (l2_resp) begin
                m_ph = 2;
            end else begin
                m_wait++;
                if (m_wait >= TMO) m_err = 1'b1;
            end
        end else begin
            m_ph = 0;
        end
    endtask

    task automatic settle();
        bit busy, ir_e, dr_e;
        #4;
        busy = (m_ph == 1);
        ir_e = busy && !m_own_d && l2_resp;
        dr_e = busy && m_own_d && l2_resp;
        chk("l2_read", l2_read, busy && !m_wr);
        chk("l2_write", l2_write, busy && m_wr);
        chk("l2_address", l2_address, m_addr);
        chk("l2_wdata", l2_wdata, m_wdata);
        chk("icache_resp", icache_resp, ir_e);
        chk("dcache_resp", dcache_resp, dr_e);
        chk("icache_rdata", icache_rdata, ir_e ? l2_rdata : 128'd0);
        chk("dcache_rdata", dcache_rdata, dr_e ? l2_rdata : 128'd0);
        chk("timeout_err", timeout_err, m_err);
    endtask

    task automatic edge_();
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_update();
        #1;
    endtask

    task automatic tick();
        settle();
        edge_();
    endtask

    task automatic serve(input int lat, input logic [127:0] d);
        l2_resp = 1'b0;
        for (int i = 0; i < lat; i++) tick();
        l2_resp  = 1'b1;
        l2_rdata = d;
        settle();
        cap_ir     = icache_resp;
        cap_dr     = dcache_resp;
        cap_irdata = icache_rdata;
        cap_drdata = dcache_rdata;
        edge_();
        l2_resp  = 1'b0;
        l2_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    initial begin
        logic       got_d [4];
        logic [3:0] exp_d;
        int         dpulses;
        int         k;

        rst_n          = 1'b0;
        icache_read    = 1'b0;
        icache_address = '0;
        dcache_read    = 1'b0;
        dcache_write   = 1'b0;
        dcache_address = '0;
        dcache_wdata   = '0;
        l2_rdata       = '0;
        l2_resp        = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        tick();
        rst_n = 1'b1;

        // Reset in the middle of a write-back
        dcache_write   = 1'b1;
        dcache_address = 16'h9999;
        dcache_wdata   = 128'h5555;
        tick();
        dcache_write = 1'b0;
        settle();
        chk("pre_reset_l2_write", l2_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_l2_write", l2_write, 1'b0);
        chk("rst_l2_read", l2_read, 1'b0);
        chk("rst_l2_address", l2_address, 16'h0);
        chk("rst_l2_wdata", l2_wdata, 128'h0);
        chk("rst_resp", {icache_resp, dcache_resp}, 2'b00);
        chk("rst_timeout", timeout_err, 1'b0);
        model_reset();
        edge_();
        rst_n = 1'b1;

        // Tie right after reset: I-cache wins, then 3-cycle I-read
        icache_read    = 1'b1;
        icache_address = 16'h1234;
        dcache_read    = 1'b1;
        dcache_address = 16'h4444;
        tick();
        dcache_read = 1'b0;
        settle();
        chk("iread_l2_read", l2_read, 1'b1);
        chk("iread_addr", l2_address, 16'h1234);
        edge_();
        serve(2, 128'h1CACE);
        chk("iread_resp", cap_ir, 1'b1);
        chk("iread_rdata", cap_irdata, 128'h1CACE);
        chk("iread_no_dresp", cap_dr, 1'b0);
        icache_read = 1'b0;
        settle();
        chk("done_no_req", {l2_read, l2_write}, 2'b00);
        edge_();
        tick();

        // D-cache write-back, wdata latched at grant
        dcache_write   = 1'b1;
        dcache_address = 16'h5678;
        dcache_wdata   = 128'hDEAD_BEEF;
        tick();
        dcache_wdata   = {$urandom, $urandom, $urandom, $urandom};
        dcache_address = 16'h0;
        settle();
        chk("dwr_l2_write", l2_write, 1'b1);
        chk("dwr_wdata", l2_wdata, 128'hDEAD_BEEF);
        chk("dwr_addr", l2_address, 16'h5678);
        edge_();
        dpulses = 0;
        serve(1, 128'h0);
        if (cap_dr) dpulses++;
        dcache_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            if (dcache_resp) dpulses++;
            edge_();
        end
        chk("dwr_one_pulse", dpulses, 1);

        // Contention: both held high for four transactions
        icache_read    = 1'b1;
        icache_address = 16'h1111;
        dcache_read    = 1'b1;
        dcache_address = 16'h2222;
        for (int t = 0; t < 4; t++) begin
            tick();
            serve(t % 3, 128'(t + 100));
            chk("rr_single_resp", cap_ir ^ cap_dr, 1'b1);
            got_d[t] = cap_dr;
            tick();
        end
        icache_read = 1'b0;
        dcache_read = 1'b0;
        exp_d = 4'b1010;
        for (int t = 0; t < 4; t++)
            chk($sformatf("rr_grant%0d", t), got_d[t], exp_d[t]);
        tick();

        // Withdrawal after grant
        dcache_read    = 1'b1;
        dcache_address = 16'hABCD;
        tick();
        dcache_read = 1'b0;
        settle();
        chk("wd_l2_read", l2_read, 1'b1);
        edge_();
        serve(2, 128'hF00D);
        chk("wd_dresp", cap_dr, 1'b1);
        chk("wd_drdata", cap_drdata, 128'hF00D);
        tick();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            if (!icache_read && ($urandom % 3 == 0)) begin
                icache_read    = 1'b1;
                icache_address = 16'($urandom);
            end
            if (!dcache_read && !dcache_write && ($urandom % 3 == 0)) begin
                k              = int'($urandom % 3);
                dcache_read    = (k != 1);
                dcache_write   = (k != 0);
                dcache_address = 16'($urandom);
            end
            dcache_wdata = {$urandom, $urandom, $urandom, $urandom};
            l2_rdata     = {$urandom, $urandom, $urandom, $urandom};
            if (m_ph == 1) l2_resp = ($urandom % 3 == 0) || (m_wait >= 5);
            else l2_resp = ($urandom % 4 == 0);
            settle();
            cap_ir = icache_resp;
            cap_dr = dcache_resp;
            edge_();
            if (cap_ir) icache_read = 1'b0;
            if (cap_dr) begin
                dcache_read  = 1'b0;
                dcache_write = 1'b0;
            end
        end
        icache_read  = 1'b0;
        dcache_read  = 1'b0;
        dcache_write = 1'b0;
        for (int i = 0; i < 20 && m_ph != 0; i++) begin
            l2_resp = (m_ph == 1);
            tick();
        end
        l2_resp = 1'b0;
        chk("drain_idle", m_ph, 0);

        // Watchdog: no response for TMO busy cycles
        icache_read    = 1'b1;
        icache_address = 16'h0BAD;
        tick();
        icache_read = 1'b0;
        for (int i = 0; i < TMO; i++) begin
            settle();
            chk("wdog_quiet", timeout_err, 1'b0);
            edge_();
        end
        settle();
        chk("wdog_set", timeout_err, 1'b1);
        chk("wdog_still_busy", l2_read, 1'b1);
        edge_();
        tick();
        serve(0, 128'h7);
        chk("late_iresp", cap_ir, 1'b1);
        tick();
        settle();
        chk("wdog_sticky", timeout_err, 1'b1);
        edge_();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l2_mem_arbiter.md
Name: l2_mem_arbiter

Overview:
Registered arbiter that shares the single L2/physical-memory line port between the L1 I-cache (read-only) and the L1 D-cache (read/write) in the mp3 memory hierarchy. It sits between the two L1 controllers and the L2 cache, and presents one outstanding line transaction at a time. Simultaneous requests are resolved round-robin, and the address and write line are latched at grant. A watchdog flags a lower level that never responds.

Parameters:
ADDR_W, 16, address width (lc3b_word)
LINE_W, 128, cache line width (lc3b_l1_line)
TIMEOUT, 255, max cycles in a busy state without l2_resp before timeout_err sets (1..1023)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
icache_read  in  1  I-cache line read request (level, held until icache_resp)
icache_address  in  ADDR_W  I-cache line address
icache_rdata  out  LINE_W  line returned to I-cache
icache_resp  out  1  one-cycle completion pulse to I-cache
dcache_read  in  1  D-cache line read request
dcache_write  in  1  D-cache line write-back request
dcache_address  in  ADDR_W  D-cache line address
dcache_wdata  in  LINE_W  D-cache write-back line
dcache_rdata  out  LINE_W  line returned to D-cache
dcache_resp  out  1  one-cycle completion pulse to D-cache
l2_read  out  1  read request to L2
l2_write  out  1  write request to L2
l2_address  out  ADDR_W  latched address to L2
l2_wdata  out  LINE_W  latched write line to L2
l2_rdata  in  LINE_W  L2 read line
l2_resp  in  1  L2 completion pulse
timeout_err  out  1  sticky watchdog flag

Behaviour:
- Clock is clk. Reset is rst_n: asynchronous and active-low. Reset forces state IDLE, last_grant=DCACHE (so the first tie goes to the I-cache), latched addr/wdata=0, watchdog=0, timeout_err=0, and all outputs to 0 immediately. A reset mid-transaction drops l2_read/l2_write in the same instant. No resp pulse is issued for the aborted transaction.
- States: IDLE, I_RD, D_RD, D_WR, DONE.
- IDLE grant rules:
  - Only the I-cache requests: go to I_RD.
  - Only the D-cache requests: go to D_WR if dcache_write, else D_RD.
  - Both request: grant the requester not equal to last_grant.
  - dcache_read and dcache_write both high: treated as a write.
- At the grant edge: latch the granted address (and dcache_wdata for D_WR) and update last_grant.
- l2_read=1 in I_RD and D_RD. l2_write=1 in D_WR. Both are Moore outputs of registered state, first asserted the cycle after the request is seen in IDLE (1-cycle grant latency). l2_address and l2_wdata come from the latch registers and are stable for the whole transaction.
- Requester inputs are ignored while busy. Deasserting a request after grant does not cancel it: the transaction completes and the resp pulse is still issued.
- On a cycle with l2_resp=1 in a busy state:
  - the owner's resp is 1 in that same cycle (combinational);
  - icache_rdata/dcache_rdata = l2_rdata in that cycle, 0 otherwise;
  - next state is DONE.
- l2_resp is ignored in IDLE and DONE.
- DONE: one turnaround cycle with no L2 request and no grant. This lets the owner drop its request. It then goes to IDLE, so back-to-back transactions are spaced by at least 2 idle L2 cycles.
- Watchdog:
  - Counter clears on entry to any busy state and increments each busy cycle without l2_resp; it saturates.
  - When it reaches TIMEOUT, timeout_err sets and stays set until reset. The FSM keeps waiting.
- Fairness: with both requesters held high continuously, grants strictly alternate.

Test Plan:
- Reset check: assert rst_n=0 mid-D_WR -> l2_write=0 asynchronously, all outputs 0. After release, an icache_read at 0x1234 is granted first.
- I-read: icache_read=1, addr 0x1234; L2 answers 128'h1CACE after 3 cycles -> l2_read=1 with l2_address=0x1234 from the cycle after the request; icache_resp=1 with icache_rdata=128'h1CACE on the resp cycle; DONE, then IDLE.
- D-write: dcache_write=1, addr 0x5678, wdata 128'hDEAD_BEEF -> l2_write=1, l2_wdata latched even if dcache_wdata changes the next cycle; dcache_resp pulses once.
- Contention: icache_read and dcache_read held high for 4 transactions -> grant order I, D, I, D; no cycle with both resp high.
- Withdrawal: dcache_read dropped the cycle after grant -> l2_read stays asserted until l2_resp; dcache_resp still pulses.
- Timeout: TIMEOUT=8, l2_resp never asserted -> timeout_err rises after 8 busy cycles and stays 1 after a late l2_resp.
